// File: rtl/sonar_pkg.sv
// -----------------------------------------------------------------------------
// sonar_pkg
// Shared types and constants for the sonar distance scheduler.
//   poll_state_t : sensor read sequencer states
//   zone_t       : motor zone decided from the filtered distance
//   distance_t   : raw / filtered distance in sensor counts (22 bits)
//   SONIC_REG    : sensor register holding the distance
// -----------------------------------------------------------------------------
package sonar_pkg;

    localparam int DIST_W = 22;

    typedef logic [DIST_W-1:0] distance_t;

    localparam logic [2:0] SONIC_REG = 3'h0;

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_REQ     = 2'd1,
        P_WAIT    = 2'd2,
        P_CAPTURE = 2'd3
    } poll_state_t;

    typedef enum logic [1:0] {
        Z_STOP = 2'd0,
        Z_MID  = 2'd1,
        Z_FAR  = 2'd2
    } zone_t;

endpackage

// File: rtl/median3.sv
// -----------------------------------------------------------------------------
// median3
// Combinational median of three unsigned distances.
//   i_a, i_b, i_c : candidate distances
//   o_median      : the middle value of the three
// -----------------------------------------------------------------------------
module median3
    import sonar_pkg::*;
(
    input  distance_t i_a,
    input  distance_t i_b,
    input  distance_t i_c,
    output distance_t o_median
);

    distance_t w_lo_ab;
    distance_t w_hi_ab;
    distance_t w_hi_ab_min_c;

    // median = max(min(a,b), min(max(a,b), c))
    assign w_lo_ab       = (i_a < i_b) ? i_a : i_b;
    assign w_hi_ab       = (i_a < i_b) ? i_b : i_a;
    assign w_hi_ab_min_c = (w_hi_ab < i_c) ? w_hi_ab : i_c;
    assign o_median      = (w_lo_ab > w_hi_ab_min_c) ? w_lo_ab : w_hi_ab_min_c;

endmodule

// File: rtl/sonar_scheduler.sv
// -----------------------------------------------------------------------------
// sonar_scheduler
// Periodically reads a distance from an ultrasonic sensor slave, median-filters
// it and converts the result into a motor zone (stop / mid / far speed).
//
// Ports
//   clk, reset_n       : clock (rising edge), async active-low reset
//   s_cs, s_read       : one-cycle read request to the sensor
//   s_write            : tied low, the sensor is never written
//   s_address          : always the distance register
//   s_writedata        : tied to zero
//   s_readdata         : sensor data, distance in [21:0]
//   motor_speed, run   : registered motor command
//   sample_valid       : one-cycle pulse when distance updates
//   distance           : median-filtered distance
//
// Poll FSM
//   state     | meaning
//   P_IDLE    | waiting for the interval counter to wrap
//   P_REQ     | s_cs/s_read asserted for one cycle
//   P_WAIT    | waiting out the remaining read latency
//   P_CAPTURE | s_readdata is valid and sampled
//
// Zone FSM
//   state  | meaning
//   Z_STOP | motor disabled, speed 0
//   Z_MID  | motor enabled at SPEED_MID
//   Z_FAR  | motor enabled at SPEED_FAR
// -----------------------------------------------------------------------------
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int POLL_CYCLES = 2500000,
    parameter int RD_LATENCY  = 1,
    parameter int NEAR_TH     = 1000,
    parameter int FAR_TH      = 100000,
    parameter int HYST        = 200,
    parameter int SPEED_MID   = 4500,
    parameter int SPEED_FAR   = 3000,
    parameter int MAX_INVALID = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        s_cs,
    output logic        s_read,
    output logic        s_write,
    output logic [2:0]  s_address,
    output logic [31:0] s_writedata,
    input  logic [31:0] s_readdata,
    output logic [31:0] motor_speed,
    output logic        run,
    output logic        sample_valid,
    output logic [21:0] distance
);

    localparam logic [31:0] POLL_TC   = 32'(POLL_CYCLES - 1);
    // WAIT is entered only when RD_LATENCY > 1 and lasts RD_LATENCY-1 cycles.
    localparam logic [2:0]  WAIT_LOAD = 3'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);
    localparam int          INV_W     = $clog2(MAX_INVALID + 1);
    localparam logic [INV_W-1:0] INV_MAX = INV_W'(MAX_INVALID);

    // Thresholds widened to 23 bits so the +HYST sums cannot wrap.
    localparam logic [22:0] TH_FAR_ENTER = 23'(FAR_TH);
    localparam logic [22:0] TH_MID_ENTER = 23'(NEAR_TH + HYST);
    localparam logic [22:0] TH_NEAR_EXIT = 23'(NEAR_TH);
    localparam logic [22:0] TH_FAR_UP    = 23'(FAR_TH + HYST);
    localparam logic [22:0] TH_FAR_EXIT  = 23'(FAR_TH - HYST);

    // ------------------------------------------------------------------
    // Poll sequencer
    // ------------------------------------------------------------------
    poll_state_t r_poll_state;
    poll_state_t w_poll_next;
    logic [31:0] r_interval;
    logic        w_interval_tc;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_next;

    assign w_interval_tc = (r_interval == POLL_TC);

    // The interval counter free-runs in every poll state so the read period
    // does not stretch with the read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_interval   <= 32'd0;
            r_poll_state <= P_IDLE;
            r_wait_cnt   <= 3'd0;
        end else begin
            r_interval   <= w_interval_tc ? 32'd0 : (r_interval + 32'd1);
            r_poll_state <= w_poll_next;
            r_wait_cnt   <= w_wait_next;
        end
    end

    always_comb begin
        w_poll_next = r_poll_state;
        w_wait_next = r_wait_cnt;
        unique case (r_poll_state)
            P_IDLE: begin
                if (w_interval_tc) begin
                    w_poll_next = P_REQ;
                end
            end
            P_REQ: begin
                if (RD_LATENCY > 1) begin
                    w_poll_next = P_WAIT;
                    w_wait_next = WAIT_LOAD;
                end else begin
                    w_poll_next = P_CAPTURE;
                end
            end
            P_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_poll_next = P_CAPTURE;
                end else begin
                    w_wait_next = r_wait_cnt - 3'd1;
                end
            end
            P_CAPTURE: begin
                w_poll_next = P_IDLE;
            end
            default: begin
                w_poll_next = P_IDLE;
            end
        endcase
    end

    assign s_cs        = (r_poll_state == P_REQ);
    assign s_read      = (r_poll_state == P_REQ);
    assign s_write     = 1'b0;
    assign s_address   = SONIC_REG;
    assign s_writedata = 32'd0;

    // ------------------------------------------------------------------
    // Sample validation and median filter
    // ------------------------------------------------------------------
    // The 3-entry window is the sample being captured plus the two previous
    // accepted samples; filtering on arrival lets distance register in the
    // same edge that retires CAPTURE.
    distance_t        w_raw;
    logic             w_capture;
    logic             w_raw_ok;
    distance_t        r_hist1;
    distance_t        r_hist2;
    logic             r_primed;
    logic [INV_W-1:0] r_invalid;
    distance_t        w_med_b;
    distance_t        w_med_c;
    distance_t        w_median;
    distance_t        r_distance;
    logic             r_sample_valid;
    logic             w_unused_rd;

    assign w_raw       = s_readdata[21:0];
    assign w_unused_rd = ^s_readdata[31:22];
    assign w_capture   = (r_poll_state == P_CAPTURE);
    assign w_raw_ok    = (w_raw != '0);

    // Before the first accepted sample the window is prefilled with it.
    assign w_med_b = r_primed ? r_hist1 : w_raw;
    assign w_med_c = r_primed ? r_hist2 : w_raw;

    median3 u_median3 (
        .i_a      (w_raw),
        .i_b      (w_med_b),
        .i_c      (w_med_c),
        .o_median (w_median)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist1        <= '0;
            r_hist2        <= '0;
            r_primed       <= 1'b0;
            r_invalid      <= '0;
            r_distance     <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_capture) begin
                if (w_raw_ok) begin
                    r_hist1        <= w_raw;
                    r_hist2        <= w_med_b;
                    r_primed       <= 1'b1;
                    r_invalid      <= '0;
                    r_distance     <= w_median;
                    r_sample_valid <= 1'b1;
                end else if (r_invalid != INV_MAX) begin
                    r_invalid <= r_invalid + 1'b1;
                end
            end
        end
    end

    assign distance     = r_distance;
    assign sample_valid = r_sample_valid;

    // ------------------------------------------------------------------
    // Zone FSM
    // ------------------------------------------------------------------
    zone_t       r_zone;
    zone_t       w_zone_next;
    logic [22:0] w_dist_ext;
    logic        w_force_stop;
    logic        r_run;
    logic [31:0] r_motor_speed;
    logic [31:0] w_speed_next;

    assign w_dist_ext   = {1'b0, r_distance};
    assign w_force_stop = (r_invalid == INV_MAX);

    // A fresh sample takes priority over the invalid-run stop.
    always_comb begin
        w_zone_next = r_zone;
        if (r_sample_valid) begin
            unique case (r_zone)
                Z_STOP: begin
                    if (w_dist_ext >= TH_FAR_ENTER) begin
                        w_zone_next = Z_FAR;
                    end else if (w_dist_ext >= TH_MID_ENTER) begin
                        w_zone_next = Z_MID;
                    end
                end
                Z_MID: begin
                    if (w_dist_ext < TH_NEAR_EXIT) begin
                        w_zone_next = Z_STOP;
                    end else if (w_dist_ext >= TH_FAR_UP) begin
                        w_zone_next = Z_FAR;
                    end
                end
                Z_FAR: begin
                    if (w_dist_ext < TH_NEAR_EXIT) begin
                        w_zone_next = Z_STOP;
                    end else if (w_dist_ext < TH_FAR_EXIT) begin
                        w_zone_next = Z_MID;
                    end
                end
                default: begin
                    w_zone_next = Z_STOP;
                end
            endcase
        end else if (w_force_stop) begin
            w_zone_next = Z_STOP;
        end
    end

    always_comb begin
        w_speed_next = 32'd0;
        unique case (w_zone_next)
            Z_MID:   w_speed_next = 32'(SPEED_MID);
            Z_FAR:   w_speed_next = 32'(SPEED_FAR);
            default: w_speed_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zone        <= Z_STOP;
            r_run         <= 1'b0;
            r_motor_speed <= 32'd0;
        end else begin
            r_zone        <= w_zone_next;
            r_run         <= (w_zone_next != Z_STOP);
            r_motor_speed <= w_speed_next;
        end
    end

    assign run         = r_run;
    assign motor_speed = r_motor_speed;

endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
REQ-002 POLL_CYCLES, 2500000, clock cycles between read starts (50 ms at 50 MHz).
REQ-003 RD_LATENCY, 1, cycles from read-strobe cycle to valid s_readdata (range 1..7).
REQ-004 NEAR_TH / FAR_TH, 1000 / 100000, zone thresholds in raw 22-bit distance counts.
REQ-005 HYST, 200, hysteresis in counts applied on leaving a zone.
REQ-006 SPEED_MID / SPEED_FAR, 4500 / 3000, motor_speed value per zone.
REQ-007 MAX_INVALID, 4, consecutive invalid samples before forced stop.
REQ-008 The block SHALL have these ports (name, direction, width, meaning):
REQ-009 clk  in  1  single clock, rising edge.
REQ-010 reset_n  in  1  reset, asynchronous and active-low.
REQ-011 s_cs / s_read / s_write  out  1 each  sensor slave select, read and write strobes.
REQ-012 s_address  out  3  sensor register address, always 3'h0 (distance register).
REQ-013 s_writedata  out  32  constant 0.
REQ-014 s_readdata  in  32  sensor data, distance in bits [21:0].
REQ-015 motor_speed  out  32  commanded speed.
REQ-016 run  out  1  motor enable.
REQ-017 sample_valid  out  1  one-cycle pulse when filtered distance updates.
REQ-018 distance  out  22  current median-filtered distance.

Function
REQ-019 The poll FSM SHALL have states IDLE, REQ, WAIT and CAPTURE.
REQ-020 IDLE: 32-bit interval counter counts to POLL_CYCLES-1, then wraps to 0 and enters REQ.
REQ-021 REQ: s_cs=1 and s_read=1 for exactly one cycle; outside REQ both are 0; s_write SHALL always be 0.
REQ-022 WAIT: hold for RD_LATENCY-1 cycles, then enter CAPTURE; with RD_LATENCY=1, WAIT lasts 0 cycles.
REQ-023 CAPTURE: sample s_readdata[21:0] in one cycle, then return to IDLE.
REQ-024 The interval counter SHALL run in every state, so the read period is exactly POLL_CYCLES.
REQ-025 A raw sample of 0 SHALL be invalid: it increments a saturating invalid counter and is not pushed into the filter.
REQ-026 A nonzero sample SHALL clear the invalid counter and shift into a 3-deep history.
REQ-027 distance SHALL equal the median of the 3 history entries, registered, and update in the cycle after CAPTURE, together with sample_valid=1.
REQ-028 The zone FSM SHALL have states STOP, MID and FAR and evaluate only on sample_valid.
REQ-029 From STOP: go to FAR if distance >= FAR_TH, else to MID if distance >= NEAR_TH+HYST.
REQ-030 From MID: go to STOP if distance < NEAR_TH; go to FAR if distance >= FAR_TH+HYST.
REQ-031 From FAR: go to STOP if distance < NEAR_TH; go to MID if distance < FAR_TH-HYST.
REQ-032 Outputs SHALL be registered: STOP gives run=0 and motor_speed=0; MID gives run=1 and SPEED_MID; FAR gives run=1 and SPEED_FAR.
REQ-033 When the invalid counter reaches MAX_INVALID, the zone SHALL go to STOP immediately and stay there until the next sample_valid.
REQ-034 If forced stop and a sample_valid occur in the same cycle, the sample_valid SHALL win.
REQ-035 Comparisons SHALL be unsigned at 23 bits so that NEAR_TH+HYST and FAR_TH+HYST cannot overflow.

Reset
REQ-036 On reset_n low, all state SHALL clear asynchronously: poll FSM to IDLE, counter 0, history 0, invalid counter 0, zone STOP.
REQ-037 Output reset values SHALL be: run=0, motor_speed=0, distance=0, sample_valid=0, s_cs=0, s_read=0.
REQ-038 Reset asserted mid-read SHALL abort the read; a late s_readdata SHALL be ignored.
REQ-039 The first read after reset release SHALL start POLL_CYCLES cycles later.
REQ-040 The filter SHALL prefill: the first valid sample after reset is copied into all 3 history entries.

Structure
REQ-041 A shared package sonar_pkg SHALL hold the poll_state_t and zone_t enums, the SONIC_REG address constant and the 22-bit distance_t typedef.
REQ-042 The block SHALL contain one sub-module, median3 (combinational, three 22-bit in, one out).

Verification
REQ-043 POLL_CYCLES=100, RD_LATENCY=1, constant readdata 50000 -> s_read pulses at cycles 100, 200, ...; first sample gives distance=50000; zone MID, run=1, motor_speed=4500.
REQ-044 Samples 50000, 50000, 0, 0, 0, 0 -> after the 4th zero, run=0 and motor_speed=0; the next sample 50000 restores MID.
REQ-045 Hysteresis: from MID, sample 100100 -> stays MID; 100200 x3 -> FAR (3000); then 99850 x3 -> stays FAR; 99799 x3 -> MID.
REQ-046 Spike: history 50000, 50000, then single 900 -> median 50000, stays MID; 900 x2 -> STOP.
REQ-047 RD_LATENCY=3 -> capture occurs 3 cycles after the s_read cycle; readdata changed at latency 2 is not taken.
REQ-048 reset_n pulled low during WAIT -> all outputs 0 immediately; no sample_valid from the aborted read.
